// File: rtl/sdp_nrdma_eg_ctx.sv
// sdp_nrdma_eg_ctx: tracks read contexts against returned DMA beats and forwards them through a 2-entry skid with boundary flags
module sdp_nrdma_eg_ctx #(
  parameter int DW = 256
) (
  input  logic          nvdla_core_clk_mgated,
  input  logic          nvdla_core_rstn,
  input  logic          op_en,
  input  logic          cq2eg_pvld,
  output logic          cq2eg_prdy,
  input  logic [15:0]   cq2eg_pd,
  input  logic          dma_rd_rsp_pvld,
  output logic          dma_rd_rsp_prdy,
  input  logic [DW-1:0] dma_rd_rsp_pd,
  output logic          eg2dp_pvld,
  input  logic          eg2dp_prdy,
  output logic [DW+2:0] eg2dp_pd,
  output logic          layer_done,
  output logic [31:0]   layer_beats,
  output logic          eg_idle
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;
  state_e        state_q, state_d;
  logic          ctx_vld_q, ctx_vld_d;
  logic [6:0]    ctx_q, ctx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    sk_cnt_q, sk_cnt_d;
  logic [DW+2:0] sk0_q, sk0_d, sk1_q, sk1_d;
  logic [31:0]   layer_beats_q, layer_beats_d;
  logic [DW+2:0] din;
  logic [1:0]    wr_pos;
  logic          rsp_acc, rsp_last, cq_acc, out_acc;
  logic          unused_rsvd;

  assign unused_rsvd     = ^cq2eg_pd[15:7];
  assign eg2dp_pvld      = sk_cnt_q != 2'd0;
  assign eg2dp_pd        = sk0_q;
  assign out_acc         = eg2dp_pvld && eg2dp_prdy;
  assign dma_rd_rsp_prdy = ctx_vld_q && (sk_cnt_q != 2'd2 || eg2dp_prdy);
  assign rsp_acc         = dma_rd_rsp_pvld && dma_rd_rsp_prdy;
  assign rsp_last        = rsp_acc && cnt_q == ctx_q[3:0];
  // popping stops once the layer_end context finishes, so nothing is fetched past the layer
  assign cq2eg_prdy      = state_q == ACTIVE && (!ctx_vld_q || (rsp_last && !ctx_q[6]));
  assign cq_acc          = cq2eg_pvld && cq2eg_prdy;
  assign din             = {ctx_q[6:4] & {3{rsp_last}}, dma_rd_rsp_pd};
  assign wr_pos          = sk_cnt_q - {1'b0, out_acc};
  assign layer_done      = out_acc && sk0_q[DW+2];
  assign layer_beats     = layer_beats_q;
  assign eg_idle         = state_q == IDLE && !ctx_vld_q && sk_cnt_q == 2'd0;

  // layer sequencing: wait for enable, run until the layer_end beat, then wait for disable and drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = op_en ? ACTIVE : IDLE;
      ACTIVE:  state_d = (rsp_last && ctx_q[6]) ? DONE : ACTIVE;
      DONE:    state_d = (!op_en && sk_cnt_q == 2'd0) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // context register with same-cycle reload on the last beat, plus beat counter and statistics
  always_comb begin
    ctx_vld_d     = cq_acc ? 1'b1 : (rsp_last ? 1'b0 : ctx_vld_q);
    ctx_d         = cq_acc ? cq2eg_pd[6:0] : ctx_q;
    cnt_d         = rsp_last ? 4'd0 : (rsp_acc ? cnt_q + 4'd1 : cnt_q);
    layer_beats_d = (state_q == IDLE && op_en) ? 32'd0 : layer_beats_q + {31'd0, out_acc};
  end

  // skid FIFO: shift on pop, then write the incoming beat into the first free slot
  always_comb begin
    sk_cnt_d = sk_cnt_q + {1'b0, rsp_acc} - {1'b0, out_acc};
    sk0_d    = out_acc ? sk1_q : sk0_q;
    sk1_d    = sk1_q;
    if (rsp_acc && wr_pos == 2'd0) sk0_d = din;
    if (rsp_acc && wr_pos == 2'd1) sk1_d = din;
  end

  // state registers, cleared asynchronously so a mid-layer reset discards everything held
  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q       <= IDLE;
      ctx_vld_q     <= 1'b0;
      ctx_q         <= '0;
      cnt_q         <= '0;
      sk_cnt_q      <= '0;
      sk0_q         <= '0;
      sk1_q         <= '0;
      layer_beats_q <= '0;
    end else begin
      state_q       <= state_d;
      ctx_vld_q     <= ctx_vld_d;
      ctx_q         <= ctx_d;
      cnt_q         <= cnt_d;
      sk_cnt_q      <= sk_cnt_d;
      sk0_q         <= sk0_d;
      sk1_q         <= sk1_d;
      layer_beats_q <= layer_beats_d;
    end
  end
endmodule

// File: doc/sdp_nrdma_eg_ctx.md
# sdp_nrdma_eg_ctx

Egress context tracker for the SDP NRDMA read path. It pops 16-bit read-context entries from the NRDMA context queue (cq2eg) and counts returned DMA read beats against each context. It forwards the beats to the SDP datapath through a 2-entry registered skid buffer, tagged with line, surface and layer boundary flags. It also reports per-layer completion and beat statistics.

## Interface
- DW, 256, DMA read response data width in bits.
- nvdla_core_clk_mgated  in  1  clock.
- nvdla_core_rstn  in  1  reset: asynchronous, active-low.
- op_en  in  1  layer enable; level, from register file.
- cq2eg_pvld  in  1  context entry valid.
- cq2eg_prdy  out  1  context entry accepted.
- cq2eg_pd  in  16  context: [3:0] beat_cnt_m1, [4] line_end, [5] surf_end, [6] layer_end, [15:7] reserved (ignored).
- dma_rd_rsp_pvld  in  1  DMA response beat valid.
- dma_rd_rsp_prdy  out  1  DMA response beat accepted.
- dma_rd_rsp_pd  in  DW  response data.
- eg2dp_pvld  out  1  output beat valid.
- eg2dp_prdy  in  1  datapath ready.
- eg2dp_pd  out  DW+3  {layer_end, surf_end, line_end, data}; flags are set only on the last beat of a context.
- layer_done  out  1  one-cycle pulse when the layer_end beat is accepted downstream.
- layer_beats  out  32  beats accepted downstream since the last op_en rising edge.
- eg_idle  out  1  high when the FSM is IDLE, no context is held and the skid is empty.

## Operation
- Context register:
  - ctx_vld, ctx fields, beat_cnt[3:0].
  - cq2eg_prdy = (state==ACTIVE) && (!ctx_vld || rsp_last_acc), where rsp_last_acc = beat accepted && beat_cnt==beat_cnt_m1.
  - Prefetch gives back-to-back contexts with no bubble.
- dma_rd_rsp_prdy = ctx_vld && skid not full (fewer than 2 entries, or one leaving this cycle). A beat arriving with no context stalls indefinitely; it is never dropped.
- On accepted beat:
  - If not last: beat_cnt increments.
  - If last: beat_cnt clears to 0 and ctx_vld = cq2eg_pvld && cq2eg_prdy, loading the new context in the same cycle if one is popped.
- beat_cnt_m1=0 means a 1-beat context; 15 means 16 beats. The 4-bit counter never wraps past beat_cnt_m1.
- FSM:
  - IDLE -> ACTIVE when op_en=1; layer_beats clears on this transition.
  - ACTIVE -> DONE in the cycle the layer_end beat is accepted into the skid. No further contexts are popped after that beat.
  - DONE -> IDLE when op_en=0 and the skid is empty.
- op_en falling while ACTIVE is ignored. The block keeps draining until the layer_end beat; software must not drop op_en mid-layer.
- Skid: 2-entry FIFO with registered output. eg2dp_pvld = entry0 valid. No combinational path from eg2dp_prdy to dma_rd_rsp_prdy beyond the skid-full term.
- layer_beats increments on each eg2dp_pvld && eg2dp_prdy. It is 32-bit and wraps modulo 2^32.
- layer_done asserts in the cycle an output beat with layer_end=1 is accepted downstream.

## Timing
- Reset values: cq2eg_prdy=0, dma_rd_rsp_prdy=0, eg2dp_pvld=0, eg2dp_pd=0, layer_done=0, layer_beats=0, eg_idle=1; FSM=IDLE, ctx_vld=0, beat_cnt=0, skid empty.
- cq pop to first rsp_prdy: 1 cycle (context registered).
- Response beat accepted at cycle N -> eg2dp_pvld at N+1.
- Throughput is 1 beat/cycle sustained, including across context boundaries.
- eg2dp_prdy low: the skid absorbs 2 beats, then dma_rd_rsp_prdy deasserts in the cycle after the second fill. Output data is held stable while pvld && !prdy.
- Reset asserted mid-layer: all state clears asynchronously, and held skid data and contexts are discarded.

## Test plan
- Single context, beat_cnt_m1=3, layer_end=1; 4 beats D0..D3; eg2dp_prdy=1 -> D0..D3 appear at cycles N+1..N+4, flags only on D3, layer_done pulse with D3, layer_beats=4, FSM reaches DONE; op_en=0 -> IDLE, eg_idle=1.
- Three back-to-back contexts (m1=0, m1=15, m1=1 with line_end); continuous beats -> 19 beats with no bubble, line_end only on beat 19, cq pops at beats 0, 1 and 17.
- Beats presented with cq empty for 10 cycles -> dma_rd_rsp_prdy=0 throughout and nothing lost; context pushed -> data flows 1 cycle later.
- eg2dp_prdy=0 for 5 cycles during a 16-beat context -> 2 beats buffered, rsp_prdy low, output held stable; release -> order preserved, total 16 beats.
- Reset pulsed after 7 of 16 beats -> all outputs return to reset values; new layer restarts cleanly with layer_beats counting from 0.
- layer_beats preloaded near 2^32-1 via forced long run -> wraps to 0, no stall.
